// File: rtl/hc_pkg.sv
// Shared types and encodings for the buffer responder.
package hc_pkg;
  localparam int BUF_ID_W = 4;
  localparam int OFFSET_W = 16;
  localparam int LEN_W    = 16;

  typedef logic [BUF_ID_W-1:0] t_buffer_id;
  typedef logic [OFFSET_W-1:0] t_request_cmd_offset;

  typedef enum logic {
    MODE_STREAM  = 1'b0,
    MODE_INDEXED = 1'b1
  } t_req_mode;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } t_issue_state;

  typedef struct packed {
    t_req_mode           mode;
    t_buffer_id          buffer;
    t_request_cmd_offset offset;
    logic [LEN_W-1:0]    len;
  } t_rd_req;

  function automatic logic id_ok(input t_buffer_id id, input int n_buffers);
    return (int'(id) < n_buffers);
  endfunction
endpackage

// File: rtl/hc_buffer_responder_if.sv
// Request/response bundle between a requester (master) and the responder (slave).
interface hc_buffer_responder_if import hc_pkg::*; #(parameter int DATA_W = 512);
  logic                rd_req_valid;
  t_req_mode           rd_req_mode;
  t_buffer_id          rd_req_buffer;
  t_request_cmd_offset rd_req_offset;
  logic [15:0]         rd_req_len;
  logic                rd_full;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_req_valid;
  t_req_mode           wr_req_mode;
  t_buffer_id          wr_req_buffer;
  t_request_cmd_offset wr_req_offset;
  logic [DATA_W-1:0]   wr_req_data;
  logic [31:0]         rd_words;
  logic [31:0]         wr_words;
  logic                err;

  modport master (
    output rd_req_valid, rd_req_mode, rd_req_buffer, rd_req_offset, rd_req_len,
    output wr_req_valid, wr_req_mode, wr_req_buffer, wr_req_offset, wr_req_data,
    input  rd_full, rd_valid, rd_data, rd_words, wr_words, err
  );

  modport slave (
    input  rd_req_valid, rd_req_mode, rd_req_buffer, rd_req_offset, rd_req_len,
    input  wr_req_valid, wr_req_mode, wr_req_buffer, wr_req_offset, wr_req_data,
    output rd_full, rd_valid, rd_data, rd_words, wr_words, err
  );
endinterface

// File: rtl/hc_req_fifo.sv
// Synchronous read-request queue; pushes while full and pops while empty are dropped.
module hc_req_fifo import hc_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  t_rd_req                push_data_i,
  input  logic                   pop_i,
  output t_rd_req                head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  t_rd_req      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/hc_buffer_responder.sv
// Multi-buffer memory responder: queued stream/indexed reads with fixed latency, unthrottled writes.
// state | meaning: ST_IDLE = queue empty, nothing to issue; ST_ISSUE = issuing words of cur_q
module hc_buffer_responder import hc_pkg::*; #(
  parameter int N_BUFFERS  = 2,
  parameter int DEPTH      = 1024,
  parameter int DATA_W     = 512,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  hc_buffer_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (N_BUFFERS > 1) ? $clog2(N_BUFFERS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  t_issue_state      state_q, state_d;
  t_rd_req           cur_q, cur_d, head, push_req;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              pop, fifo_empty, cur_ok, cur_last, rd_err, issue_en, wr_ok;
  logic [CW-1:0]     fifo_count;
  logic [BW-1:0]     issue_buf, wr_buf;
  logic [AW-1:0]     issue_addr, wr_addr;
  logic [AW-1:0]     rd_ptr_q [N_BUFFERS];
  logic [AW-1:0]     wr_ptr_q [N_BUFFERS];
  logic [DATA_W-1:0] mem [N_BUFFERS][DEPTH];
  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [DATA_W-1:0] pipe_dat_q [RD_LATENCY];
  logic              err_q;
  logic [31:0]       rd_words_q, wr_words_q;
  logic              unused_offset_hi;

  assign push_req = t_rd_req'{mode: bus.rd_req_mode, buffer: bus.rd_req_buffer,
                              offset: bus.rd_req_offset, len: bus.rd_req_len};
  assign bus.rd_full = (fifo_count == CW'(FIFO_DEPTH));

  hc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.rd_req_valid),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign cur_ok     = id_ok(cur_q.buffer, N_BUFFERS);
  assign issue_buf  = cur_q.buffer[BW-1:0];
  assign issue_addr = (cur_q.mode == MODE_INDEXED) ? cur_q.offset[AW-1:0] : rd_ptr_q[issue_buf];

  // The next head is popped on the last-word cycle so back-to-back requests issue without a bubble.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    remain_d = remain_q;
    pop      = 1'b0;
    issue_en = 1'b0;
    cur_last = 1'b0;
    rd_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cur_d    = head;
          remain_d = head.len;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_err   = !cur_ok;
        issue_en = cur_ok && ((cur_q.mode == MODE_INDEXED) || (remain_q != '0));
        cur_last = !cur_ok || (cur_q.mode == MODE_INDEXED) || (remain_q <= 16'd1);
        if (issue_en) remain_d = remain_q - 16'd1;
        if (cur_last) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            cur_d    = head;
            remain_d = head.len;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_ok   = bus.wr_req_valid && id_ok(bus.wr_req_buffer, N_BUFFERS);
  assign wr_buf  = bus.wr_req_buffer[BW-1:0];
  assign wr_addr = (bus.wr_req_mode == MODE_INDEXED) ? bus.wr_req_offset[AW-1:0] : wr_ptr_q[wr_buf];
  assign unused_offset_hi = ^{cur_q.offset[OFFSET_W-1:AW], bus.wr_req_offset[OFFSET_W-1:AW]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      remain_q   <= '0;
      err_q      <= 1'b0;
      rd_words_q <= '0;
      wr_words_q <= '0;
      for (int b = 0; b < N_BUFFERS; b++) begin
        rd_ptr_q[b] <= '0;
        wr_ptr_q[b] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      remain_q <= remain_d;
      if (issue_en && (cur_q.mode == MODE_STREAM))
        rd_ptr_q[issue_buf] <= rd_ptr_q[issue_buf] + 1'b1;
      if (wr_ok && (bus.wr_req_mode == MODE_STREAM))
        wr_ptr_q[wr_buf] <= wr_ptr_q[wr_buf] + 1'b1;
      if (rd_err || (bus.wr_req_valid && !wr_ok)) err_q <= 1'b1;
      if (bus.wr_req_valid) wr_words_q <= wr_words_q + 32'd1;
      if (pipe_vld_q[RD_LATENCY-1]) rd_words_q <= rd_words_q + 32'd1;
    end
  end

  // Read pipeline; memory is read in the issue cycle, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) pipe_dat_q[s] <= '0;
    end else begin
      pipe_vld_q[0] <= issue_en;
      if (issue_en) pipe_dat_q[0] <= mem[issue_buf][issue_addr];
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_dat_q[s] <= pipe_dat_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_buf][wr_addr] <= bus.wr_req_data;
  end

  assign bus.rd_valid = pipe_vld_q[RD_LATENCY-1];
  assign bus.rd_data  = pipe_dat_q[RD_LATENCY-1];
  assign bus.err      = err_q;
  assign bus.rd_words = rd_words_q;
  assign bus.wr_words = wr_words_q;
endmodule
